alu_seq: RTL and testbench

Registered, handshaked, N-bit successor to the datapath's combinational ALU. Executes one operation per Start request on latched operands, commits result and a full NZCV flag set into output registers, and signals completion with a one-cycle Done pulse. Adds an optional iterative shift-add multiplier. Sits between the register-file read stage and the write-back/branch logic of the multicycle processor.

---
 rtl/alu_seq.sv | 158 +++++++++++++++
 tb/tb_alu_seq.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Registered, handshaked N-bit ALU: one operation per Start, result and NZCV flags committed to registers, Done pulses for one cycle.
// Define ALU_MUL_EN to compile in the iterative shift-add multiplier (opcode 1000); otherwise 1000 behaves as an undefined opcode.
module alu_seq #(
  parameter int N = 64
) (
  input  logic         CLK,
  input  logic         Reset,
  input  logic         Start,
  input  logic [3:0]   ALUCtrl,
  input  logic [N-1:0] BusA,
  input  logic [N-1:0] BusB,
  output logic         Busy,
  output logic         Done,
  output logic [N-1:0] BusW,
  output logic         Zero,
  output logic         Negative,
  output logic         Carry,
  output logic         Overflow
);

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_LSL   = 4'b0011;
  localparam logic [3:0] OP_LSR   = 4'b0100;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_PASSB = 4'b0111;
`ifdef ALU_MUL_EN
  localparam logic [3:0] OP_MUL   = 4'b1000;
  localparam int         CW       = $clog2(N);
`endif
  localparam logic [N-1:0] NW = N'(N);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
`ifdef ALU_MUL_EN
    MUL  = 2'd1,
`endif
    DONE = 2'd2
  } state_t;

  state_t state, nextState;

  logic [N-1:0] res;
  logic         resC;
  logic         resV;

`ifdef ALU_MUL_EN
  logic [2*N-1:0] acc;
  logic [2*N-1:0] mcand;
  logic [2*N-1:0] accNext;
  logic [N-1:0]   mpr;
  logic [CW-1:0]  cnt;

  assign accNext = mpr[0] ? acc + mcand : acc;
`endif

  // Status outputs decode the state register only, so nothing reaches them combinationally from inputs
  assign Busy = (state != IDLE);
  assign Done = (state == DONE);

  always_ff @(posedge CLK) begin
    if (Reset) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (Start) begin
`ifdef ALU_MUL_EN
          if (ALUCtrl == OP_MUL) nextState = MUL;
          else
`endif
          nextState = DONE;
        end
      end
`ifdef ALU_MUL_EN
      MUL:  if (cnt == '0) nextState = DONE;
`endif
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    res  = '0;
    resC = 1'b0;
    resV = 1'b0;
    case (ALUCtrl)
      OP_AND:   res = BusA & BusB;
      OP_OR:    res = BusA | BusB;
      OP_ADD: begin
        {resC, res} = {1'b0, BusA} + {1'b0, BusB};
        resV = (BusA[N-1] == BusB[N-1]) && (res[N-1] != BusA[N-1]);
      end
      OP_LSL:   res = (BusB >= NW) ? '0 : BusA << BusB;
      OP_LSR:   res = (BusB >= NW) ? '0 : BusA >> BusB;
      OP_SUB: begin
        res  = BusA - BusB;
        resC = (BusA >= BusB);
        resV = (BusA[N-1] != BusB[N-1]) && (res[N-1] != BusA[N-1]);
      end
      OP_PASSB: res = BusB;
      default:  res = '0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      BusW     <= '0;
      Zero     <= 1'b1;
      Negative <= 1'b0;
      Carry    <= 1'b0;
      Overflow <= 1'b0;
`ifdef ALU_MUL_EN
      acc      <= '0;
      mcand    <= '0;
      mpr      <= '0;
      cnt      <= '0;
`endif
    end else if (state == IDLE && Start) begin
`ifdef ALU_MUL_EN
      if (ALUCtrl == OP_MUL) begin
        acc   <= '0;
        mcand <= {{N{1'b0}}, BusA};
        mpr   <= BusB;
        cnt   <= CW'(N - 1);
      end else
`endif
      begin
        BusW     <= res;
        Zero     <= (res == '0);
        Negative <= res[N-1];
        Carry    <= resC;
        Overflow <= resV;
      end
    end
`ifdef ALU_MUL_EN
    else if (state == MUL) begin
      acc   <= accNext;
      mcand <= mcand << 1;
      mpr   <= mpr >> 1;
      cnt   <= cnt - CW'(1);
      // Last iteration commits the freshly accumulated product rather than waiting a cycle
      if (cnt == '0) begin
        BusW     <= accNext[N-1:0];
        Zero     <= (accNext[N-1:0] == '0);
        Negative <= accNext[N-1];
        Carry    <= |accNext[2*N-1:N];
        Overflow <= 1'b0;
      end
    end
`endif
  end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboarded bench for alu_seq (N=64): driver pushes model results, a negedge monitor pops on every Done.
module tb_alu_seq;

  localparam int N = 64;

  logic         CLK = 1'b0;
  logic         Reset = 1'b1;
  logic         Start = 1'b0;
  logic [3:0]   ALUCtrl = '0;
  logic [N-1:0] BusA = '0;
  logic [N-1:0] BusB = '0;
  logic         Busy, Done, Zero, Negative, Carry, Overflow;
  logic [N-1:0] BusW;

  alu_seq #(.N(N)) dut (
    .CLK(CLK), .Reset(Reset), .Start(Start), .ALUCtrl(ALUCtrl),
    .BusA(BusA), .BusB(BusB), .Busy(Busy), .Done(Done), .BusW(BusW),
    .Zero(Zero), .Negative(Negative), .Carry(Carry), .Overflow(Overflow)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [63:0] w;
    logic [3:0]  f;
    int          lat;
    int          doneCyc;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   muls = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic finishRun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // Reference: spec arithmetic in wider integers
  function automatic exp_t model(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    exp_t e;
    logic [64:0]  s;
    logic [127:0] p;
    logic c, v;
    c = 1'b0; v = 1'b0; e.lat = 0; e.w = '0; e.doneCyc = 0;
    case (op)
      4'd0: e.w = a & b;
      4'd1: e.w = a | b;
      4'd2: begin
        s = {1'b0, a} + {1'b0, b}; e.w = s[63:0]; c = s[64];
        s = {a[63], a} + {b[63], b}; v = (s[64] != s[63]);
      end
      4'd3: e.w = (b >= 64) ? 64'd0 : a << b;
      4'd4: e.w = (b >= 64) ? 64'd0 : a >> b;
      4'd6: begin
        e.w = a - b; c = (a >= b);
        s = {a[63], a} - {b[63], b}; v = (s[64] != s[63]);
      end
      4'd7: e.w = b;
`ifdef ALU_MUL_EN
      4'd8: begin
        p = {64'd0, a} * {64'd0, b};
        e.w = p[63:0]; c = (p[127:64] != 0); e.lat = N;
      end
`endif
      default: e.w = '0;
    endcase
    e.f = {(e.w == 64'd0), e.w[63], c, v};
    return e;
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge
  task automatic issue(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    exp_t e;
    int n;
    n = 0;
    while (Busy) begin
      Start = 1'b1;
      ALUCtrl = 4'($urandom);
      BusA = rnd64();
      BusB = rnd64();
      @(negedge CLK);
      n++;
      if (n > 300) begin
        checks++; errors++;
        $display("FAIL busyTimeout: Busy still %b after %0d cycles, required 0", Busy, n);
        finishRun();
      end
    end
    ALUCtrl = op; BusA = a; BusB = b; Start = 1'b1;
    e = model(op, a, b);
    e.doneCyc = cyc + 1 + e.lat;
    sb.push_back(e);
    @(negedge CLK);
    Start = 1'b0;
    ALUCtrl = 4'($urandom);
    BusA = rnd64();
    BusB = rnd64();
  endtask

  task automatic checkResetValues(input string tag);
    check({tag, "_Busy"}, 64'(Busy), 64'd0);
    check({tag, "_Done"}, 64'(Done), 64'd0);
    check({tag, "_BusW"}, BusW, 64'd0);
    check({tag, "_flags"}, 64'({Zero, Negative, Carry, Overflow}), 64'b1000);
  endtask

  always @(negedge CLK) begin
    if (!Reset && Done) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL spuriousDone: Done=1 at cycle %0d, required no pending operation", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("BusW", BusW, e.w);
        check("flagsZNCV", 64'({Zero, Negative, Carry, Overflow}), 64'(e.f));
        check("doneCycle", 64'(cyc), 64'(e.doneCyc));
      end
    end
  end

  initial begin
    logic [3:0]  op;
    logic [63:0] a, b;
    int n;
    repeat (3) @(negedge CLK);
    Reset = 1'b0;
    checkResetValues("reset");

    issue(4'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
    issue(4'd2, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
    issue(4'd6, 64'd5, 64'd7);
    issue(4'd6, 64'd7, 64'd5);
    issue(4'd3, 64'd1, 64'd64);
    issue(4'd4, 64'h8000_0000_0000_0000, 64'd63);
    issue(4'd3, 64'd1, 64'd63);
    issue(4'd4, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_0000_0000);
    issue(4'd8, 64'h1_0000_0000, 64'h1_0000_0001);
    issue(4'd7, 64'd0, 64'h8000_0000_0000_0001);
    issue(4'd5, 64'hFFFF, 64'hFFFF);

    for (int i = 0; i < 150; i++) begin
      op = 4'($urandom_range(0, 15));
      if (op == 4'd8) begin
        if (muls >= 30) op = 4'd2;
        else muls++;
      end
      a = rnd64();
      b = rnd64();
      if ($urandom_range(0, 3) == 0) a = 64'($urandom_range(0, 255));
      if ((op == 4'd3 || op == 4'd4) && $urandom_range(0, 1) == 1) b = 64'($urandom_range(0, 70));
      if (op == 4'd8 && $urandom_range(0, 1) == 1) b = 64'($urandom);
      issue(op, a, b);
    end

`ifdef ALU_MUL_EN
    issue(4'd8, rnd64(), rnd64());
    repeat (19) @(negedge CLK);
    check("busyMidMul", 64'(Busy), 64'd1);
`else
    issue(4'd2, 64'd1, 64'd1);
`endif
    Reset = 1'b1;
    @(negedge CLK);
    Reset = 1'b0;
    sb.delete();
    checkResetValues("abort");
    repeat (80) @(negedge CLK);
    check("idleAfterAbort", 64'(Busy), 64'd0);

    issue(4'd6, 64'd0, 64'd1);

    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge CLK);
      n++;
    end
    check("drainPending", 64'(sb.size()), 64'd0);
    @(negedge CLK);
    finishRun();
  end

endmodule
